// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
// Keeps counter sizing in one place for every switch instance.
package switch_debounce_pkg;

    function automatic int cnt_width(input int limit);
        if (limit < 1)
            return 1;
        return (limit == 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous pad bit.
// Reusable for every switch input on the board.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RESET_VAL;
            q  <= RESET_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Debounces one push-button: synchronized, counted, registered level
// plus single-cycle rise/fall strobes.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int CW = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

    if (DEBOUNCE_LIMIT < 1) begin : g_bad_limit
        $error("switch_debounce: DEBOUNCE_LIMIT must be >= 1");
    end

    logic          s2;
    logic [CW-1:0] cnt;

    sync_2ff #(
        .RESET_VAL(RESET_LEVEL)
    ) u_sync (
        .clk  (i_Clk),
        .rst_n(i_Rst_L),
        .d    (i_Switch),
        .q    (s2)
    );

    // Any return to the current level restarts the count.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Switch <= RESET_LEVEL;
            o_Rise   <= 1'b0;
            o_Fall   <= 1'b0;
            cnt      <= '0;
        end else begin
            o_Rise <= 1'b0;
            o_Fall <= 1'b0;
            unique case (1'b1)
                (s2 == o_Switch): begin
                    cnt <= '0;
                end
                (s2 != o_Switch && cnt == LAST): begin
                    o_Switch <= s2;
                    o_Rise   <= s2;
                    o_Fall   <= !s2;
                    cnt      <= '0;
                end
                default: begin
                    cnt <= cnt + CW'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with DEBOUNCE_LIMIT=4, RESET_LEVEL=0.
// Per-edge vectors are queued as expectations and popped after each edge.
module tb_switch_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_in;
    logic o_sw;
    logic o_r;
    logic o_f;

    always #5 clk = ~clk;

    switch_debounce #(
        .DEBOUNCE_LIMIT(4),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .i_Switch(sw_in),
        .o_Switch(o_sw),
        .o_Rise  (o_r),
        .o_Fall  (o_f)
    );

    typedef struct {
        logic in;
        logic sw;
        logic rise;
        logic fall;
    } vec_t;

    vec_t main_v[$];
    vec_t post_v[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push_vec(input bit post, input logic in,
                            input logic sw, input logic r,
                            input logic f);
        vec_t v;
        v.in   = in;
        v.sw   = sw;
        v.rise = r;
        v.fall = f;
        if (post)
            post_v.push_back(v);
        else
            main_v.push_back(v);
    endtask

    // Hold `in` for n edges; level flips from lvl0 at edge `fire`.
    task automatic push_seq(input bit post, input logic in, input int n,
                            input logic lvl0, input int fire);
        for (int k = 1; k <= n; k++) begin
            logic sw;
            sw = (fire != 0 && k >= fire) ? in : lvl0;
            push_vec(post, in, sw, (k == fire) && in, (k == fire) && !in);
        end
    endtask

    task automatic check(input string name, input logic [2:0] act,
                         input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: sw/rise/fall got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act,
                             input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge.
    task automatic run(input bit post, input string tag);
        vec_t vs[$];
        vec_t e;
        vs = post ? post_v : main_v;
        foreach (vs[i]) begin
            sw_in = vs[i].in;
            sb.push_back(vs[i]);
            @(posedge clk);
            #1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL %s%0d: scoreboard empty got 0 want 1", tag, i);
            end else begin
                total--;
                e = sb.pop_front();
                check($sformatf("%s%0d", tag, i), {o_sw, o_r, o_f},
                      {e.sw, e.rise, e.fall});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit got expired want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        sw_in = 1'b0;

        // release with pad high: rise at edge 6
        push_seq(0, 1'b1, 8, 1'b0, 6);
        // 3-cycle low glitch from debounced 1
        for (int k = 0; k < 3; k++) push_vec(0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_seq(0, 1'b1, 6, 1'b1, 0);
        push_seq(0, 1'b0, 8, 1'b1, 6);
        push_seq(0, 1'b1, 8, 1'b0, 6);
        push_seq(0, 1'b0, 8, 1'b1, 6);
        // bounce 1,1,1,0,1...: count restarts, fires at edge 10
        for (int k = 1; k <= 12; k++) begin
            logic in;
            in = (k != 4);
            push_vec(0, in, k >= 10, k == 10, 1'b0);
        end
        push_seq(0, 1'b0, 8, 1'b1, 6);
        push_seq(1, 1'b1, 8, 1'b0, 6);

        #1;
        check("reset_async", {o_sw, o_r, o_f}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {o_sw, o_r, o_f}, 3'b000);
        check_int("reset_cnt", int'(dut.cnt), 0);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sw_in = ~sw_in;
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d", k), {o_sw, o_r, o_f}, 3'b000);
        end

        @(negedge clk);
        rst_n = 1'b1;
        run(0, "main");

        for (int k = 1; k <= 4; k++) begin
            sw_in = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("mid_pre%0d", k), {o_sw, o_r, o_f}, 3'b000);
            @(negedge clk);
        end
        check_int("mid_cnt", int'(dut.cnt), 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst", {o_sw, o_r, o_f}, 3'b000);
        check_int("mid_rst_cnt", int'(dut.cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
